// File: rtl/kmeans_apb_master.sv
// APB initiator for the K-means accelerator: single read/write commands in,
// one SETUP/ACCESS transfer each with wait-state timeout, response out; sticky IRQ capture.
module kmeans_apb_master #(
   parameter int addrWidth      = 9,
   parameter int dataWidth      = 91,
   parameter int timeout_cycles = 255,
   parameter int timeout_width  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   // Request and response channels: a beat moves on any rising edge where valid & ready.
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_write,
   input  logic [addrWidth-1:0] cmd_addr,
   input  logic [dataWidth-1:0] cmd_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [dataWidth-1:0] rsp_rdata,
   output logic                 rsp_timeout,
   output logic                 psel,
   output logic                 penable,
   output logic                 pwrite,
   output logic [addrWidth-1:0] paddr,
   output logic [dataWidth-1:0] pwdata,
   input  logic                 pready,
   input  logic [dataWidth-1:0] prdata,
   input  logic                 interupt,
   input  logic                 irq_clear,
   output logic                 irq_pending
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   localparam logic [timeout_width-1:0] tmo_last = timeout_width'(timeout_cycles);

   state_t                   state, state_nxt;
   logic [timeout_width-1:0] wait_cnt;
   logic                     irq_d;
   logic                     tmo_hit;

   // A late pready on the last allowed cycle still counts as a normal completion.
   assign tmo_hit = (state == ACCESS) && !pready && (wait_cnt == tmo_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      psel      = 1'b0;
      penable   = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nxt = SETUP;
         end
         SETUP: begin
            psel      = 1'b1;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (pready || tmo_hit) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // APB address/data/control hold their last values outside a transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         wait_cnt    <= '0;
         rsp_rdata   <= '0;
         rsp_timeout <= 1'b0;
      end else begin
         if (state == IDLE && cmd_valid) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
         end
         if (state == SETUP) wait_cnt <= '0;
         if (state == ACCESS) begin
            if (pready) begin
               rsp_rdata   <= pwrite ? '0 : prdata;
               rsp_timeout <= 1'b0;
            end else if (tmo_hit) begin
               rsp_rdata   <= '0;
               rsp_timeout <= 1'b1;
            end else begin
               wait_cnt <= wait_cnt + timeout_width'(1);
            end
         end
      end
   end

   // Edge-detected interrupt; a new edge beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_d       <= 1'b0;
         irq_pending <= 1'b0;
      end else begin
         irq_d <= interupt;
         if (interupt && !irq_d) irq_pending <= 1'b1;
         else if (irq_clear)     irq_pending <= 1'b0;
      end
   end

endmodule

// File: tb/tb_kmeans_apb_master.sv
// Directed bench for kmeans_apb_master: phase checks per transfer, response scoreboard,
// interrupt edge/clear behaviour and asynchronous reset mid-transfer.
module tb_kmeans_apb_master;
   localparam int AW  = 9;
   localparam int DW  = 91;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_ready, rsp_timeout;
   logic [DW-1:0] rsp_rdata;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic          pready;
   logic [DW-1:0] prdata;
   logic          interupt, irq_clear, irq_pending;

   logic [DW:0]   exp_q[$];
   int            checks = 0;
   int            errors = 0;

   kmeans_apb_master #(.addrWidth(AW), .dataWidth(DW), .timeout_cycles(TMO), .timeout_width(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .pready(pready), .prdata(prdata),
      .interupt(interupt), .irq_clear(irq_clear), .irq_pending(irq_pending)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] junk();
      logic [95:0] j;
      j = {$urandom(), $urandom(), $urandom()};
      return j[DW-1:0];
   endfunction

   // One command; slave asserts pready after `waits` wait states (never if waits > TMO).
   task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int waits, input logic [DW-1:0] rd, input int bp);
      int            acc;
      int            exp_acc;
      logic [DW:0]   exp;
      logic [DW-1:0] held;
      chk("idle_cmd_ready", cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
      if (waits > TMO) exp_q.push_back({1'b1, {DW{1'b0}}});
      else             exp_q.push_back({1'b0, wr ? {DW{1'b0}} : rd});
      tick();
      cmd_valid = 1'b0; cmd_wdata = junk(); cmd_addr = ~addr; cmd_write = ~wr;
      chk("setup_psel", psel, 1'b1);
      chk("setup_penable", penable, 1'b0);
      chk("setup_paddr", paddr, addr);
      chk("setup_pwrite", pwrite, wr);
      chk("setup_pwdata", pwdata, wd);
      tick();
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         if (!(psel === 1'b1 && penable === 1'b1)) break;
         acc++;
         chk("access_paddr", paddr, addr);
         chk("access_pwdata", pwdata, wd);
         chk("access_pwrite", pwrite, wr);
         if (i == waits) begin pready = 1'b1; prdata = rd; end
         else            begin pready = 1'b0; prdata = junk(); end
         tick();
      end
      pready = 1'b0; prdata = junk();
      exp_acc = (waits > TMO) ? TMO + 1 : waits + 1;
      chk("access_cycles", acc, exp_acc);
      held = rsp_rdata;
      for (int j = 0; j < bp; j++) begin
         rsp_ready = 1'b0;
         chk("bp_rsp_valid", rsp_valid, 1'b1);
         chk("bp_cmd_ready", cmd_ready, 1'b0);
         chk("bp_psel", psel, 1'b0);
         chk("bp_rdata_stable", rsp_rdata, held);
         tick();
      end
      rsp_ready = 1'b1;
      chk("resp_valid", rsp_valid, 1'b1);
      chk("resp_psel", psel, 1'b0);
      chk("resp_penable", penable, 1'b0);
      if (exp_q.size() == 0) begin
         chk("scoreboard_nonempty", 1'b0, 1'b1);
      end else begin
         exp = exp_q.pop_front();
         chk("resp_data_timeout", {rsp_timeout, rsp_rdata}, exp);
      end
      tick();
      rsp_ready = 1'b0;
      chk("after_rsp_valid", rsp_valid, 1'b0);
      chk("after_cmd_ready", cmd_ready, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0; pready = 1'b0; prdata = '0; interupt = 1'b0; irq_clear = 1'b0;
      repeat (3) tick();
      chk("rst_psel", psel, 1'b0);
      chk("rst_penable", penable, 1'b0);
      chk("rst_paddr", paddr, '0);
      chk("rst_pwdata", pwdata, '0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_irq_pending", irq_pending, 1'b0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_cmd_ready", cmd_ready, 1'b1);

      // Write zero wait, read with 3 waits, timeout, pready on the last allowed cycle.
      do_xfer(1'b1, 9'h010, 91'h1234, 0, junk(), 0);
      do_xfer(1'b0, 9'h044, 91'h0, 3, 91'h5A5A, 0);
      do_xfer(1'b0, 9'h0C8, 91'h0, 99, 91'h7777, 0);
      do_xfer(1'b0, 9'h0C9, 91'h0, TMO, 91'h3C3C, 0);
      do_xfer(1'b0, 9'h1AB, 91'h0, 1, 91'hDEAD_BEEF_0123_4567, 5);
      do_xfer(1'b1, 9'h1FF, {DW{1'b1}}, 99, junk(), 2);
      for (int k = 0; k < 6; k++)
         do_xfer(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), junk(),
                 $urandom_range(0, 6), junk(), $urandom_range(0, 2));

      // Interrupt: one set per rising edge, level does not re-arm after clear.
      interupt = 1'b1;
      chk("irq_before_edge", irq_pending, 1'b0);
      tick();
      chk("irq_set", irq_pending, 1'b1);
      for (int c = 1; c < 10; c++) begin
         irq_clear = (c == 5);
         tick();
         chk("irq_level_hold", irq_pending, (c < 5) ? 1'b1 : 1'b0);
      end
      irq_clear = 1'b0; interupt = 1'b0;
      tick(); tick();
      chk("irq_low_idle", irq_pending, 1'b0);
      interupt = 1'b1; irq_clear = 1'b1;
      tick();
      chk("irq_set_beats_clear", irq_pending, 1'b1);
      interupt = 1'b0; irq_clear = 1'b0;
      tick();
      chk("irq_held_pending", irq_pending, 1'b1);

      // Asynchronous reset in the middle of an ACCESS phase.
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h155; cmd_wdata = 91'hABCD;
      tick();
      cmd_valid = 1'b0;
      tick();
      pready = 1'b0;
      tick();
      chk("pre_rst_access", {psel, penable}, 2'b11);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_psel", psel, 1'b0);
      chk("mid_rst_penable", penable, 1'b0);
      chk("mid_rst_pwrite", pwrite, 1'b0);
      chk("mid_rst_paddr", paddr, '0);
      chk("mid_rst_pwdata", pwdata, '0);
      chk("mid_rst_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, '0);
      chk("mid_rst_irq", irq_pending, 1'b0);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("post_abort_no_rsp", rsp_valid, 1'b0);
         chk("post_abort_ready", cmd_ready, 1'b1);
      end
      do_xfer(1'b0, 9'h0A5, 91'h0, 2, 91'h1357_9BDF, 1);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
